// File: rtl/load_store_unit_if.sv
// Word-wide variable-latency data-memory port between the load/store unit and memory.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns ALU address + rs2 into a byte-enabled word access,
// stalls the core while memory is busy and returns extended load data or a fault code.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [2:0]                Funct3,
    input  logic [31:0]               ALUResult,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      Stall,
    output logic                      Done,
    output logic [1:0]                FaultCode,
    load_store_unit_if.master         mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] read_data_q, read_data_d;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit;

    function automatic logic illegal_width(input logic [2:0] f3, input logic is_store);
        if (is_store) return (f3 > 3'd2);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b0;
            default:                                return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Counter holds the number of BUSY cycles already completed, so this cycle is the limit.
    assign timeout_hit = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        read_data_d = read_data_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        Stall       = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall       = 1'b1;
                    funct3_d    = Funct3;
                    off_d       = ALUResult[1:0];
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {ALUResult[31:2], 2'b00};
                    mem_be_d    = MemWrite ? store_be(Funct3, ALUResult[1:0]) : 4'b1111;
                    mem_wdata_d = MemWrite ? store_wdata(Funct3, WriteData) : 32'h0;
                    read_data_d = 32'h0;
                    cnt_d       = 16'h0;
                    if (illegal_width(Funct3, MemWrite)) begin
                        fault_d = FC_ILLEGAL;
                        state_d = DONE;
                    end else if (misaligned(Funct3, ALUResult[1:0])) begin
                        fault_d = FC_MISALIGN;
                        state_d = DONE;
                    end else begin
                        fault_d   = FC_NONE;
                        mem_req_d = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                cnt_d = cnt_q + 16'd1;
                if (mem.mem_ready) begin
                    mem_req_d   = 1'b0;
                    fault_d     = FC_NONE;
                    read_data_d = mem_we_q ? 32'h0 : load_extract(funct3_q, off_q, mem.mem_rdata);
                    state_d     = DONE;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    fault_d     = FC_TIMEOUT;
                    read_data_d = 32'h0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            funct3_q    <= 3'h0;
            off_q       <= 2'h0;
            read_data_q <= 32'h0;
            fault_q     <= FC_NONE;
            cnt_q       <= 16'h0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Done          = (state_q == DONE);
    assign ReadData      = read_data_q;
    assign FaultCode     = fault_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

endmodule
